// File: rtl/servo_dispense_pwm_pkg.sv
// Shared types and default timing constants for the servo dispense gate.
// The defaults give a 2000-tick frame with closed/open pulse widths of 100/200 ticks.
package servo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_OPEN  = 2'd2,
        ST_CLOSE = 2'd3
    } servo_state_t;

    localparam int DEF_PERIOD        = 2000;
    localparam int DEF_CLOSED_W      = 100;
    localparam int DEF_OPEN_W        = 200;
    localparam int DEF_HOLD_FRAMES   = 25;
    localparam int DEF_SETTLE_FRAMES = 25;

endpackage

// File: rtl/servo_dispense_pwm_frame.sv
// PWM frame generator: the tick-driven frame counter, a width latched only at frame
// boundaries, and the registered servo line.
module pwm_frame_gen
    import servo_pkg::*;
#(
    parameter int CNT_W    = 12,
    parameter int PERIOD   = DEF_PERIOD,
    parameter int CLOSED_W = DEF_CLOSED_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] width_tgt,
    input  logic             load_en,
    output logic             fb,
    output logic             pwm_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] width_r;
    logic [CNT_W-1:0] width_nxt_s;
    logic             pwm_r;
    logic             fb_s;

    assign fb_s  = tick_i && (cnt_r == LAST_CNT);
    assign fb    = fb_s;
    assign pwm_o = pwm_r;

    // Next counter value and next active width.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        width_nxt_s = width_r;
        if (tick_i) begin
            cnt_nxt_s = (cnt_r == LAST_CNT) ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
        end else begin
            cnt_nxt_s = cnt_r;
        end
        if (fb_s && load_en) begin
            width_nxt_s = width_tgt;
        end else begin
            width_nxt_s = width_r;
        end
    end

    // Counter, width and output registers; the reset count makes the first tick a boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= LAST_CNT;
            width_r <= CNT_W'(CLOSED_W);
            pwm_r   <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            width_r <= width_nxt_s;
            if (tick_i) begin
                pwm_r <= (cnt_nxt_s < width_nxt_s);
            end else begin
                pwm_r <= pwm_r;
            end
        end
    end

endmodule

// File: rtl/servo_dispense_pwm.sv
// Dispense sequencer: on request, opens the gate for a fixed number of frames,
// closes it, waits for it to settle, then pulses done.
module servo_dispense_pwm
    import servo_pkg::*;
#(
    parameter int CNT_W         = 12,
    parameter int PERIOD        = DEF_PERIOD,
    parameter int CLOSED_W      = DEF_CLOSED_W,
    parameter int OPEN_W        = DEF_OPEN_W,
    parameter int HOLD_FRAMES   = DEF_HOLD_FRAMES,
    parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES,
    parameter int FR_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic req_i,
    output logic busy_o,
    output logic done_o,
    output logic pwm_o
);

    servo_state_t     state_r;
    servo_state_t     state_nxt_s;
    logic [FR_W-1:0]  fr_cnt_r;
    logic [FR_W-1:0]  fr_cnt_nxt_s;
    logic [CNT_W-1:0] width_tgt_s;
    logic             load_en_s;
    logic             done_nxt_s;
    logic             fb_s;
    logic             busy_r;
    logic             done_r;

    assign busy_o = busy_r;
    assign done_o = done_r;

    pwm_frame_gen #(
        .CNT_W    (CNT_W),
        .PERIOD   (PERIOD),
        .CLOSED_W (CLOSED_W)
    ) u_frame (
        .clk       (clk),
        .rst       (rst),
        .tick_i    (tick_i),
        .width_tgt (width_tgt_s),
        .load_en   (load_en_s),
        .fb        (fb_s),
        .pwm_o     (pwm_o)
    );

    // Sequencer next-state logic; all progress is gated by frame boundaries.
    always_comb begin
        state_nxt_s  = state_r;
        fr_cnt_nxt_s = fr_cnt_r;
        width_tgt_s  = CNT_W'(CLOSED_W);
        load_en_s    = 1'b0;
        done_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_i) begin
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (fb_s) begin
                    width_tgt_s  = CNT_W'(OPEN_W);
                    load_en_s    = 1'b1;
                    fr_cnt_nxt_s = {FR_W{1'b0}};
                    state_nxt_s  = ST_OPEN;
                end else begin
                    state_nxt_s = ST_ARM;
                end
            end
            ST_OPEN: begin
                if (fb_s && (fr_cnt_r == FR_W'(HOLD_FRAMES - 1))) begin
                    width_tgt_s  = CNT_W'(CLOSED_W);
                    load_en_s    = 1'b1;
                    fr_cnt_nxt_s = {FR_W{1'b0}};
                    state_nxt_s  = ST_CLOSE;
                end else if (fb_s) begin
                    fr_cnt_nxt_s = fr_cnt_r + FR_W'(1);
                end else begin
                    state_nxt_s = ST_OPEN;
                end
            end
            ST_CLOSE: begin
                if (fb_s && (fr_cnt_r == FR_W'(SETTLE_FRAMES - 1))) begin
                    fr_cnt_nxt_s = {FR_W{1'b0}};
                    done_nxt_s   = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end else if (fb_s) begin
                    fr_cnt_nxt_s = fr_cnt_r + FR_W'(1);
                end else begin
                    state_nxt_s = ST_CLOSE;
                end
            end
            default: begin
                fr_cnt_nxt_s = {FR_W{1'b0}};
                state_nxt_s  = ST_IDLE;
            end
        endcase
    end

    // State, frame counter and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            fr_cnt_r <= {FR_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            fr_cnt_r <= fr_cnt_nxt_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
            done_r   <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_servo_dispense_pwm.sv
// Randomized bench for servo_dispense_pwm against a frame-schedule reference model.
module tb_servo_dispense_pwm;

    localparam int P  = 10;
    localparam int CW = 2;
    localparam int OW = 5;
    localparam int HF = 3;
    localparam int SF = 2;

    logic clk = 1'b0;
    logic rst;
    logic tick_i;
    logic req_i;
    logic busy_o;
    logic done_o;
    logic pwm_o;

    int n_tests = 0;
    int n_fail  = 0;
    int tdiv    = 0;
    int dut_done_cnt = 0;

    // Reference model: position in frame, current width, and the queue of widths
    // still owed to the running sequence.
    int   m_pos;
    int   m_width;
    logic m_pwm;
    logic m_busy;
    logic m_done;
    int   m_seqs = 0;
    int   q[$];

    servo_dispense_pwm #(
        .CNT_W         (12),
        .PERIOD        (P),
        .CLOSED_W      (CW),
        .OPEN_W        (OW),
        .HOLD_FRAMES   (HF),
        .SETTLE_FRAMES (SF),
        .FR_W          (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick_i (tick_i),
        .req_i  (req_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .pwm_o  (pwm_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos   = P - 1;
        m_width = CW;
        m_pwm   = 1'b0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
        q.delete();
    endtask

    task automatic model_step(input logic t, input logic r);
        logic was_busy;
        logic fb;
        was_busy = m_busy;
        m_done   = 1'b0;
        if (t) begin
            fb    = (m_pos == P - 1);
            m_pos = fb ? 0 : m_pos + 1;
            if (fb && was_busy) begin
                if (q.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_seqs++;
                end else begin
                    m_width = q.pop_front();
                end
            end
            m_pwm = (m_pos < m_width);
        end
        if (!was_busy && r) begin
            m_busy = 1'b1;
            q.delete();
            repeat (HF) q.push_back(OW);
            repeat (SF) q.push_back(CW);
        end
    endtask

    // One clk cycle: drive inputs, advance DUT and model, compare all outputs.
    task automatic step(input logic req_v, input logic tick_cont);
        tick_i = tick_cont ? 1'b1 : (tdiv == 2);
        tdiv   = (tdiv == 2) ? 0 : tdiv + 1;
        req_i  = req_v;
        @(posedge clk);
        #1;
        model_step(tick_i, req_v);
        if (done_o) dut_done_cnt++;
        chk("pwm", pwm_o, m_pwm);
        chk("busy", busy_o, m_busy);
        chk("done", done_o, m_done);
    endtask

    task automatic run_until_idle(input string tag);
        int n;
        n = 0;
        while (m_busy && n < 1000) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (m_busy) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int hi_cnt;
        int d0;
        int s0;
        int n;
        rst    = 1'b0;
        tick_i = 1'b0;
        req_i  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwm", pwm_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        rst = 1'b1;

        // Idle for 40 ticks: two high ticks per frame, starting at the first tick.
        hi_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            step(1'b0, 1'b0);
            if (tick_i && pwm_o) hi_cnt++;
            if (i == 2) chk("first_tick_hi", pwm_o, 1'b1);
        end
        chk("idle_hi_ticks", hi_cnt, 8);

        // Single request in the middle of a frame.
        n = 0;
        while (m_pos != 4 && n < 100) begin step(1'b0, 1'b0); n++; end
        d0 = dut_done_cnt;
        step(1'b1, 1'b0);
        chk("busy_next_cycle", busy_o, 1'b1);
        run_until_idle("single");
        chk("single_done_cnt", dut_done_cnt - d0, 1);

        // Request landing exactly on a frame boundary.
        n = 0;
        while (!(m_pos == P - 1 && tdiv == 2) && n < 100) begin step(1'b0, 1'b0); n++; end
        d0 = dut_done_cnt;
        step(1'b1, 1'b0);
        chk("fb_req_width_closed", pwm_o, 1'b1);
        run_until_idle("fb_req");
        chk("fb_req_done_cnt", dut_done_cnt - d0, 1);

        // Random requests while busy must be ignored.
        d0 = dut_done_cnt;
        step(1'b1, 1'b0);
        n = 0;
        while (m_busy && n < 1000) begin
            step($urandom_range(0, 3) == 0, 1'b0);
            n++;
        end
        repeat (5) step(1'b0, 1'b0);
        chk("ignored_done_cnt", dut_done_cnt - d0, 1);

        // Request held high: back-to-back sequences.
        d0 = dut_done_cnt;
        s0 = m_seqs;
        repeat (700) step(1'b1, 1'b0);
        chk("held_done_cnt", dut_done_cnt - d0, m_seqs - s0);
        run_until_idle("held");

        // Continuous tick with random requests.
        for (int i = 0; i < 300; i++) step($urandom_range(0, 9) == 0, 1'b1);
        run_until_idle("cont");

        // Reset in the middle of the open phase.
        step(1'b1, 1'b0);
        n = 0;
        while (!(m_busy && q.size() <= 2) && n < 500) begin step(1'b0, 1'b0); n++; end
        if (!(m_busy && q.size() <= 2)) chk("open_timeout", 32'd0, 32'd1);
        d0 = dut_done_cnt;
        rst = 1'b0;
        #1;
        chk("midrst_pwm", pwm_o, 1'b0);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_done", done_o, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_hold_busy", busy_o, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 90; i++) step(1'b0, 1'b0);
        chk("midrst_no_done", dut_done_cnt - d0, 0);
        chk("done_total", dut_done_cnt, m_seqs);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_dispense_pwm.md
# servo_dispense_pwm

Servo pulse generator and dispense sequencer for the candy/snack gate. Sits directly downstream of the PWM clock divider: it consumes the divider's single-cycle tick as its time base and drives the servo control line. On each dispense request it opens the gate for a fixed number of PWM frames, closes it, waits for the gate to settle, then reports completion.

## Interface
- `CNT_W`, 12: width of the frame counter and the pulse-width values.
- `PERIOD`, 2000: ticks per PWM frame; legal range 2..2^CNT_W-1.
- `CLOSED_W`, 100: high time in ticks for the closed position; must be less than `PERIOD`.
- `OPEN_W`, 200: high time in ticks for the open position; must be less than `PERIOD`.
- `HOLD_FRAMES`, 25: number of full frames at `OPEN_W`; must be at least 1.
- `SETTLE_FRAMES`, 25: number of full frames at `CLOSED_W` before done; must be at least 1.
- `FR_W`, 8: width of the frame counter for the hold and settle phases.
- `clk`  in  1  the single system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `tick_i`  in  1  one-`clk` time-base pulse from the clock divider.
- `req_i`  in  1  dispense request, level-sampled in IDLE only.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse when a sequence completes.
- `pwm_o`  out  1  servo control line.

## Operation
- Frame counter `cnt`:
  - Advances only on cycles where `tick_i`=1.
  - Counts 0..`PERIOD`-1, then wraps to 0.
  - Frame boundary `fb` = `tick_i` && `cnt`==`PERIOD`-1.
- Active width `width_q`:
  - Loads only on `fb`, so each frame has a single constant pulse width and no glitches.
- `pwm_o`:
  - Registered; updates only on `tick_i` cycles.
  - `pwm_o` <= (new `cnt` < new `width_q`). On `fb` this uses the newly loaded width for count 0.
- FSM states: IDLE, ARM, OPEN, CLOSE.
  - IDLE: `width_q` target is `CLOSED_W`. If `req_i`=1, go to ARM.
  - ARM: on `fb`, load `width_q`=`OPEN_W`, clear `fr_cnt`, go to OPEN.
  - OPEN: on `fb`, if `fr_cnt`==`HOLD_FRAMES`-1, load `CLOSED_W`, clear `fr_cnt`, go to CLOSE; otherwise increment `fr_cnt`.
  - CLOSE: on `fb`, if `fr_cnt`==`SETTLE_FRAMES`-1, go to IDLE and pulse `done_o` on the next cycle; otherwise increment `fr_cnt`.
- Request handling:
  - `req_i` is ignored while busy; there is no queueing.
  - A request held high through `done_o` starts a new sequence: IDLE is occupied for exactly one cycle, then the FSM moves to ARM.
- Pulse widths:
  - Width 0 gives `pwm_o` constantly low.
  - Widths are compared unsigned at `CNT_W` bits.

## Timing
- Reset values (asynchronous, `rst`=0):
  - `cnt`=`PERIOD`-1, so the first tick wraps to 0 and is a frame boundary.
  - `width_q`=`CLOSED_W`, state=IDLE, `fr_cnt`=0.
  - `pwm_o`=0, `busy_o`=0, `done_o`=0.
- Latency:
  - `busy_o` rises the cycle after `req_i` is sampled in IDLE.
  - Open pulses start at the first frame boundary after the request.
  - The gate is open for exactly `HOLD_FRAMES` frames, then closed for exactly `SETTLE_FRAMES` frames.
  - `done_o` follows the final `fb` by one cycle; `busy_o` falls in that same cycle.
- Simultaneous events:
  - `req_i` arriving on the same cycle as `fb` in IDLE goes to ARM; the next `fb` opens the gate.
  - No events are evaluated on cycles where `tick_i`=0.
- Reset mid-sequence:
  - Aborts immediately; all outputs take their reset values.
  - No `done_o` is issued.
  - Closed pulses resume from the first tick after reset is released.
- `tick_i` held high continuously is legal: the counter then advances every `clk`.

## Structure
- `servo_pkg`:
  - State enum `servo_state_t` (IDLE, ARM, OPEN, CLOSE).
  - Default constants for `PERIOD`, `CLOSED_W`, `OPEN_W`, `HOLD_FRAMES`, `SETTLE_FRAMES`.
- One sub-module, `pwm_frame_gen`:
  - Contains `cnt`, `width_q`, `fb`, and `pwm_o`.
  - Takes a width target and a load enable.
- The top level holds the FSM, `fr_cnt`, `busy_o` and `done_o`.

## Test plan
Bench parameters: `PERIOD`=10, `CLOSED_W`=2, `OPEN_W`=5, `HOLD_FRAMES`=3, `SETTLE_FRAMES`=2, `tick_i` every 3rd `clk`.
- Reset, then idle for 40 ticks -> `pwm_o` high for 2 ticks of every 10, with a high pulse at the first tick after reset; `busy_o`=0.
- Single `req_i` pulse in IDLE mid-frame -> `busy_o` next cycle; rest of the current frame at width 2; then 3 frames at width 5; then 2 frames at width 2; then one `done_o` pulse.
- `req_i` asserted on an `fb` cycle -> ARM, and the open width is first seen at the following boundary, not the current one.
- `req_i` pulsed during OPEN and during CLOSE -> ignored; exactly one `done_o`; IDLE afterwards.
- `req_i` held high continuously -> back-to-back sequences separated by one IDLE cycle; `done_o` once per sequence.
- `rst` asserted during OPEN -> `pwm_o`=0 and `busy_o`=0 immediately; no `done_o`; closed pulses resume after release.
